// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block: condition codes,
// controller state encoding and the default datapath width.
package branch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    BR_EQ   = 3'b000,
    BR_NE   = 3'b001,
    BR_LT   = 3'b010,
    BR_LTU  = 3'b011,
    BR_GE   = 3'b100,
    BR_GEU  = 3'b101,
    BR_RSV6 = 3'b110,
    BR_RSV7 = 3'b111
  } br_ctrl_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: decides taken/not-taken from
// the condition code and the two operands.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      br_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  // Reserved encodings resolve as not-taken so they never redirect fetch.
  always_comb begin
    taken = 1'b0;
    case (br_ctrl)
      BR_EQ:   taken = (a == b);
      BR_NE:   taken = (a != b);
      BR_LT:   taken = ($signed(a) < $signed(b));
      BR_LTU:  taken = (a < b);
      BR_GE:   taken = ($signed(a) >= $signed(b));
      BR_GEU:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: captures one branch, resolves it a cycle
// later and on a mispredict redirects fetch and holds flush for FLUSH_CYCLES.
// Optional outcome counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [2:0]      br_ctrl,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic            br_pred_taken,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ready_q;
  logic [2:0]      ctrl_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic            pred_q;
  logic            taken;
  logic            in_resolve;
  logic            mispred;
  logic [XLEN-1:0] next_pc;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .br_ctrl (ctrl_q),
    .a       (rs1_q),
    .b       (rs2_q),
    .taken   (taken)
  );

  assign in_resolve = (state_q == RESOLVE);
  assign mispred    = in_resolve && (taken != pred_q);
  assign next_pc    = taken ? (pc_q + imm_q) : (pc_q + XLEN'(4));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (br_valid && ready_q) state_d = RESOLVE;
      end
      RESOLVE: begin
        // The RESOLVE cycle already counts as the first flush cycle.
        if (mispred && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // br_ready is registered so it reads 0 throughout reset rather than
  // following the IDLE state that reset forces.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      ctrl_q  <= 3'd0;
      pc_q    <= '0;
      imm_q   <= '0;
      pred_q  <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      if (br_valid && ready_q && (state_q == IDLE)) begin
        ctrl_q <= br_ctrl;
        pc_q   <= br_pc;
        imm_q  <= br_imm;
        pred_q <= br_pred_taken;
        rs1_q  <= rs1_val;
        rs2_q  <= rs2_val;
      end
    end
  end

  assign br_ready       = ready_q;
  assign resolve_valid  = in_resolve;
  assign resolve_taken  = in_resolve && taken;
  assign redirect_valid = mispred;
  assign redirect_pc    = mispred ? next_pc : '0;
  assign flush          = mispred || (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else if (in_resolve) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mispred) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign stat_branches = br_cnt_q;
  assign stat_mispred  = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed table-driven bench for branch_resolve_ctrl (default FLUSH_CYCLES=2,
// XLEN=32), plus hand sequences for held br_valid and reset during FLUSH.
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_ctrl;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        br_pred_taken;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int model_br  = 0;
  int model_mis = 0;

  typedef struct {
    string       name;
    logic [2:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        exp_taken;
    logic        exp_redir;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  branch_resolve_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_ctrl        (br_ctrl),
    .br_pc          (br_pc),
    .br_imm         (br_imm),
    .br_pred_taken  (br_pred_taken),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    br_ctrl       = v.ctrl;
    br_pc         = v.pc;
    br_imm        = v.imm;
    br_pred_taken = v.pred;
    rs1_val       = v.rs1;
    rs2_val       = v.rs2;
  endtask

  // Waits (bounded) for br_ready, offers the branch for one edge and
  // returns at the falling edge of the RESOLVE cycle.
  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    while (!br_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!br_ready) checkOutput({v.name, "_ready_timeout"}, 32'(br_ready), 32'd1);
    driveInputs(v);
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    model_br++;
    if (v.exp_redir) model_mis++;
  endtask

  initial begin
    vecs[0]  = '{"beq_hit",       3'b000, 32'h0000_0100, 32'h0000_0020, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{"blt_signed",    3'b010, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h0000_0240};
    vecs[2]  = '{"bltu_unsigned", 3'b011, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0204};
    vecs[3]  = '{"bne_wrap",      3'b001, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1'b1, 32'h0000_0010};
    vecs[4]  = '{"ctrl111",       3'b111, 32'h0000_0300, 32'h0000_0040, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"bge_signed",    3'b100, 32'h0000_0600, 32'h0000_0010, 32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{"bgeu_unsigned", 3'b101, 32'h0000_1000, 32'h0000_0010, 32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_1004};
    vecs[7]  = '{"bne_equal",     3'b001, 32'h0000_0700, 32'h0000_0008, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"ctrl110",       3'b110, 32'h0000_0300, 32'h0000_0040, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 32'h0000_0304};
    vecs[9]  = '{"beq_backward",  3'b000, 32'h0000_0400, 32'hFFFF_FFF0, 32'h0000_000A, 32'h0000_000A, 1'b0, 1'b1, 1'b1, 32'h0000_03F0};
    vecs[10] = '{"bge_equal",     3'b100, 32'h0000_0800, 32'h0000_0004, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b1, 32'h0000_0804};
    vecs[11] = '{"bgeu_pc_wrap",  3'b101, 32'hFFFF_FFFC, 32'h0000_0100, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 32'h0000_0000};

    rst = 1'b1;
    br_valid = 1'b0;
    driveInputs(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_br_ready",       32'(br_ready),       32'd0);
    checkOutput("rst_resolve_valid",  32'(resolve_valid),  32'd0);
    checkOutput("rst_resolve_taken",  32'(resolve_taken),  32'd0);
    checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("rst_redirect_pc",    redirect_pc,         32'd0);
    checkOutput("rst_flush",          32'(flush),          32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_br_ready", 32'(br_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_resolve_valid"},  32'(resolve_valid),  32'd1);
      checkOutput({vecs[i].name, "_resolve_taken"},  32'(resolve_taken),  32'(vecs[i].exp_taken));
      checkOutput({vecs[i].name, "_redirect_valid"}, 32'(redirect_valid), 32'(vecs[i].exp_redir));
      checkOutput({vecs[i].name, "_redirect_pc"},    redirect_pc,         vecs[i].exp_pc);
      checkOutput({vecs[i].name, "_flush_r"},        32'(flush),          32'(vecs[i].exp_redir));
      checkOutput({vecs[i].name, "_ready_r"},        32'(br_ready),       32'd0);
      @(negedge clk);
      if (vecs[i].exp_redir) begin
        checkOutput({vecs[i].name, "_flush_2"},       32'(flush),          32'd1);
        checkOutput({vecs[i].name, "_redir_drop"},    32'(redirect_valid), 32'd0);
        checkOutput({vecs[i].name, "_redir_pc_zero"}, redirect_pc,         32'd0);
        checkOutput({vecs[i].name, "_ready_f"},       32'(br_ready),       32'd0);
        @(negedge clk);
      end
      checkOutput({vecs[i].name, "_flush_end"},  32'(flush),         32'd0);
      checkOutput({vecs[i].name, "_rv_end"},     32'(resolve_valid), 32'd0);
      checkOutput({vecs[i].name, "_ready_back"}, 32'(br_ready),      32'd1);
    end

    // br_valid held high through RESOLVE and FLUSH: only one capture until IDLE.
    driveInputs('{"held", 3'b111, 32'h0000_0900, 32'h0000_0040, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0904});
    br_valid = 1'b1;
    @(negedge clk);
    checkOutput("held_rv1",       32'(resolve_valid),  32'd1);
    checkOutput("held_taken1",    32'(resolve_taken),  32'd0);
    checkOutput("held_redirect1", 32'(redirect_valid), 32'd1);
    checkOutput("held_pc1",       redirect_pc,         32'h0000_0904);
    driveInputs('{"held2", 3'b000, 32'h0000_0500, 32'h0000_0008, 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    checkOutput("held_flush_rv",    32'(resolve_valid), 32'd0);
    checkOutput("held_flush_ready", 32'(br_ready),      32'd0);
    checkOutput("held_flush_fl",    32'(flush),         32'd1);
    @(negedge clk);
    checkOutput("held_idle_rv",    32'(resolve_valid), 32'd0);
    checkOutput("held_idle_ready", 32'(br_ready),      32'd1);
    @(negedge clk);
    br_valid = 1'b0;
    checkOutput("held_rv2",       32'(resolve_valid),  32'd1);
    checkOutput("held_taken2",    32'(resolve_taken),  32'd1);
    checkOutput("held_redirect2", 32'(redirect_valid), 32'd0);
    model_br  += 2;
    model_mis += 1;
    @(negedge clk);
    checkOutput("held_ready_end", 32'(br_ready), 32'd1);

`ifdef BRANCH_STATS_EN
    checkOutput("stat_branches", stat_branches, 32'(model_br));
    checkOutput("stat_mispred",  stat_mispred,  32'(model_mis));
`endif

    // Reset arriving in the first FLUSH cycle aborts the flush.
    applyStimulus(vecs[1]);
    checkOutput("abort_resolve_flush", 32'(flush), 32'd1);
    @(negedge clk);
    checkOutput("abort_in_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    model_br  = 0;
    model_mis = 0;
    checkOutput("abort_flush",    32'(flush),          32'd0);
    checkOutput("abort_redirect", 32'(redirect_valid), 32'd0);
    checkOutput("abort_rv",       32'(resolve_valid),  32'd0);
    checkOutput("abort_ready",    32'(br_ready),       32'd0);
`ifdef BRANCH_STATS_EN
    checkOutput("abort_stat_branches", stat_branches, 32'(model_br));
    checkOutput("abort_stat_mispred",  stat_mispred,  32'(model_mis));
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle_ready", 32'(br_ready), 32'd1);
    checkOutput("abort_idle_flush", 32'(flush),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
- REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: number of cycles flush is held high after a mispredict (legal 1..15).
- REQ-002 SHALL have parameter XLEN, default 32: datapath width.
- REQ-003 SHALL use one clock; reset is synchronous and active-high.
- REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
- REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
- REQ-006 SHALL have port br_valid, input, 1: decode offers a branch.
- REQ-007 SHALL have port br_ready, output, 1: block accepts a branch.
- REQ-008 SHALL have port br_ctrl, input, 3: branch condition code.
- REQ-009 SHALL have port br_pc, input, XLEN: branch instruction PC.
- REQ-010 SHALL have port br_imm, input, XLEN: sign-extended offset.
- REQ-011 SHALL have port br_pred_taken, input, 1: fetch prediction.
- REQ-012 SHALL have ports rs1_val and rs2_val, input, XLEN: operands.
- REQ-013 SHALL have port resolve_valid, output, 1: one-cycle outcome pulse.
- REQ-014 SHALL have port resolve_taken, output, 1: actual outcome.
- REQ-015 SHALL have port redirect_valid, output, 1: one-cycle fetch redirect.
- REQ-016 SHALL have port redirect_pc, output, XLEN: corrected next PC.
- REQ-017 SHALL have port flush, output, 1: squash younger instructions.
- REQ-018 SHALL have ports stat_branches and stat_mispred, output, 32 each, present only under BRANCH_STATS_EN.

Function
- REQ-019 SHALL implement FSM states IDLE, RESOLVE, FLUSH.
- REQ-020 SHALL hold br_ready=1 only in IDLE with rst low.
- REQ-021 SHALL register br_ctrl, br_pc, br_imm, br_pred_taken, rs1_val, rs2_val on br_valid&&br_ready and move to RESOLVE.
- REQ-022 SHALL stay in RESOLVE exactly one cycle and pulse resolve_valid there (latency: accept edge N, outcome in cycle N+1).
- REQ-023 SHALL evaluate registered operands per br_ctrl: 000 EQ, 001 NE, 010 signed LT, 011 unsigned LT, 100 signed GE, 101 unsigned GE; 110/111 yield not-taken.
- REQ-024 SHALL compute the next PC as br_pc+br_imm when taken, else br_pc+4, both modulo 2^XLEN.
- REQ-025 SHALL, on resolve_taken != pred_taken in RESOLVE, pulse redirect_valid with redirect_pc=next PC and assert flush in that same cycle.
- REQ-026 SHALL keep flush high FLUSH_CYCLES consecutive cycles total, including the RESOLVE cycle, via a down-counter in FLUSH, then return to IDLE.
- REQ-027 SHALL bypass FLUSH and return to IDLE directly when FLUSH_CYCLES=1.
- REQ-028 SHALL return RESOLVE->IDLE when correctly predicted, with redirect_valid and flush low.
- REQ-029 SHALL hold redirect_pc at 0 whenever redirect_valid is low.
- REQ-030 SHALL drive all outputs from registered state only, with no combinational path from data inputs to outputs.

Reset
- REQ-031 SHALL, while rst is high, force IDLE, clear the flush counter and captured registers, and drive every output to 0, including br_ready.
- REQ-032 SHALL abort RESOLVE or FLUSH on rst, with flush and redirect_valid low from the next cycle.

Configuration
- REQ-033 SHALL, with BRANCH_STATS_EN defined, have stat_branches count every RESOLVE cycle and stat_mispred count every mispredicted RESOLVE cycle, wrapping at 2^32, cleared by rst.
- REQ-034 SHALL, without BRANCH_STATS_EN, omit both stat ports and counters, with behaviour otherwise identical.

Structure
- REQ-035 SHALL place br_ctrl encodings, FSM state encoding and the default XLEN in shared package branch_pkg.
- REQ-036 SHALL instantiate a single combinational sub-module branch_cmp (br_ctrl, a, b -> taken) for the condition evaluation.

Verification
- REQ-037 SHALL cover: BEQ, rs1=rs2=5, pred=1, pc=0x100, imm=0x20 -> resolve_taken=1, no redirect, br_ready back high the cycle after RESOLVE.
- REQ-038 SHALL cover: BLT, rs1=0xFFFFFFFF, rs2=1, pred=0, pc=0x200, imm=0x40 -> taken, redirect_pc=0x240, flush high 2 cycles, stat_mispred +1.
- REQ-039 SHALL cover: BLTU with the same operands, pred=1, pc=0x200 -> not taken, redirect_pc=0x204.
- REQ-040 SHALL cover: pc=0xFFFFFFF0, imm=0x20, BNE taken, pred=0 -> redirect_pc=0x00000010 (wrap).
- REQ-041 SHALL cover: br_ctrl=111 -> resolve_taken=0, and br_valid held high during RESOLVE/FLUSH -> no second capture until IDLE.
- REQ-042 SHALL cover: rst asserted in the first FLUSH cycle -> flush=0 next cycle, state IDLE, stats zero.
